// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: ALU opcodes, NZCV bit positions, MUL FSM states.
package ex_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_MUL  = 2'd1,
    MS_DONE = 2'd2
  } mul_state_e;

  // Controls captured when a MUL/MLA is accepted, replayed into the EX/MEM slot.
  typedef struct packed {
    logic       s_bit;
    logic       mem_R_en;
    logic       mem_W_en;
    logic       wb_en;
    logic [3:0] dest;
    logic [3:0] nzcv;
  } ex_ctrl_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; C/V pass through for logical and move ops.
module alu
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        exe_command,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic              c_in,
  input  logic              v_in,
  output logic [DATA_W-1:0] result_c,
  output logic [3:0]        nzcv_c
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] add_b;
  logic              cin;
  logic              arith;

  always_comb begin
    add_b    = (exe_command inside {EXE_SUB, EXE_SBC}) ? ~val2 : val2;
    cin      = 1'b0;
    arith    = 1'b0;
    result_c = '0;
    if (exe_command inside {EXE_ADC, EXE_SBC}) cin = c_in;
    if (exe_command == EXE_SUB) cin = 1'b1;
    sum = {1'b0, val1} + {1'b0, add_b} + (DATA_W+1)'(cin);
    case (exe_command)
      EXE_MOV: result_c = val2;
      EXE_MVN: result_c = ~val2;
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
        result_c = sum[DATA_W-1:0];
        arith    = 1'b1;
      end
      EXE_AND: result_c = val1 & val2;
      EXE_ORR: result_c = val1 | val2;
      EXE_EOR: result_c = val1 ^ val2;
      default: result_c = '0;
    endcase
    nzcv_c[FLAG_N] = result_c[DATA_W-1];
    nzcv_c[FLAG_Z] = (result_c == '0);
    nzcv_c[FLAG_C] = arith ? sum[DATA_W] : c_in;
    nzcv_c[FLAG_V] = arith ? ((val1[DATA_W-1] == add_b[DATA_W-1]) &&
                              (sum[DATA_W-1] != val1[DATA_W-1])) : v_in;
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier with optional early exit once the multiplier is exhausted.
module mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_RADIX  = 1,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rn,
  input  logic              mla,
  output mul_state_e        state,
  output logic [DATA_W-1:0] result_c
);

  localparam int unsigned STEPS = DATA_W / MUL_RADIX;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  mul_state_e        state_nxt;
  logic [DATA_W-1:0] rm_sh, rs_rem, rn_q, acc;
  logic [DATA_W-1:0] rs_nxt, partial;
  logic [CNT_W-1:0]  cnt;
  logic              mla_q;
  logic              last;

  always_comb begin
    rs_nxt  = rs_rem >> MUL_RADIX;
    partial = rm_sh * DATA_W'(rs_rem[MUL_RADIX-1:0]);
    last    = (cnt == CNT_W'(STEPS - 1)) || ((EARLY_TERM != 0) && (rs_nxt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE: if (start) state_nxt = MS_MUL;
      MS_MUL: begin
        if (flush)     state_nxt = MS_IDLE;
        else if (last) state_nxt = MS_DONE;
      end
      MS_DONE: state_nxt = MS_IDLE;
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_comb begin
    result_c = acc + (mla_q ? rn_q : '0);
  end

  // Operand latch on accept, one shift-add step per MUL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rm_sh  <= '0;
      rs_rem <= '0;
      rn_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      mla_q  <= 1'b0;
    end else if (start) begin
      rm_sh  <= rm;
      rs_rem <= rs;
      rn_q   <= rn;
      mla_q  <= mla;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MS_MUL) begin
      acc    <= acc + partial;
      rm_sh  <= rm_sh << MUL_RADIX;
      rs_rem <= rs_nxt;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/val2_generator.sv
// Operand-2 generator: memory offset, rotated immediate, or shifted register.
module val2_generator #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] val_rm,
  input  logic [11:0]       shift_operand,
  input  logic              imm,
  input  logic              mem_en,
  output logic [DATA_W-1:0] val2_c
);

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input int unsigned n);
    int unsigned amt;
    amt = n % DATA_W;
    return (amt == 0) ? x : ((x >> amt) | (x << (DATA_W - amt)));
  endfunction

  always_comb begin
    val2_c = '0;
    if (mem_en) begin
      val2_c = DATA_W'(shift_operand);
    end else if (imm) begin
      val2_c = ror(DATA_W'(shift_operand[7:0]), 32'({shift_operand[11:8], 1'b0}));
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2_c = val_rm << shift_operand[11:7];
        2'b01:   val2_c = val_rm >> shift_operand[11:7];
        2'b10:   val2_c = DATA_W'($signed(val_rm) >>> shift_operand[11:7]);
        default: val2_c = ror(val_rm, 32'(shift_operand[11:7]));
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_mul.sv
// Execute stage with iterative MUL/MLA; output registers form the EX/MEM slot.
module ex_stage_mul
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMM_W      = 24,
  parameter int unsigned MUL_RADIX  = 1,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        exe_command,
  input  logic              is_mul,
  input  logic              mla,
  input  logic              s_bit,
  input  logic              mem_R_en,
  input  logic              mem_W_en,
  input  logic              wb_en,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_rs,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [IMM_W-1:0]  signed_imm_24,
  input  logic [3:0]        status_reg,
  output logic              stall_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] br_addr,
  output logic [3:0]        status,
  output logic              status_we,
  output logic              mem_R_en_out,
  output logic              mem_W_en_out,
  output logic              wb_en_out,
  output logic [3:0]        dest_out,
  output logic [DATA_W-1:0] val_rm_out
);

  mul_state_e        mul_state;
  logic [DATA_W-1:0] val2_c, alu_res_c, mul_res_c, imm_sext_c, br_sum_c;
  logic [3:0]        alu_nzcv_c, mul_nzcv_c;
  logic              alu_fire_c, mul_start_c;
  ex_ctrl_t          mul_ctrl;
  logic [DATA_W-1:0] mul_val_rm, mul_br;

  assign alu_fire_c  = (mul_state == MS_IDLE) && in_valid && !is_mul && !flush;
  assign mul_start_c = (mul_state == MS_IDLE) && in_valid && is_mul && !flush;
  assign imm_sext_c  = DATA_W'($signed(signed_imm_24));
  assign br_sum_c    = pc + (imm_sext_c << 2);
  assign mul_nzcv_c  = {mul_res_c[DATA_W-1], (mul_res_c == '0), mul_ctrl.nzcv[FLAG_C], mul_ctrl.nzcv[FLAG_V]};

  val2_generator #(.DATA_W(DATA_W)) u_val2 (
    .val_rm(val_rm), .shift_operand(shift_operand), .imm(imm),
    .mem_en(mem_R_en | mem_W_en), .val2_c(val2_c)
  );

  alu #(.DATA_W(DATA_W)) u_alu (
    .exe_command(exe_command), .val1(val_rn), .val2(val2_c),
    .c_in(status_reg[FLAG_C]), .v_in(status_reg[FLAG_V]),
    .result_c(alu_res_c), .nzcv_c(alu_nzcv_c)
  );

  mul_iter #(.DATA_W(DATA_W), .MUL_RADIX(MUL_RADIX), .EARLY_TERM(EARLY_TERM)) u_mul (
    .clk(clk), .rst(rst), .flush(flush), .start(mul_start_c),
    .rm(val_rm), .rs(val_rs), .rn(val_rn), .mla(mla),
    .state(mul_state), .result_c(mul_res_c)
  );

  // Controls of the accepted MUL, replayed when its result retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_ctrl   <= '0;
      mul_val_rm <= '0;
      mul_br     <= '0;
    end else if (mul_start_c) begin
      mul_ctrl   <= '{s_bit: s_bit, mem_R_en: mem_R_en, mem_W_en: mem_W_en,
                      wb_en: wb_en, dest: dest, nzcv: status_reg};
      mul_val_rm <= val_rm;
      mul_br     <= br_sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_out    <= 1'b0;
      out_valid    <= 1'b0;
      alu_result   <= '0;
      br_addr      <= '0;
      status       <= '0;
      status_we    <= 1'b0;
      mem_R_en_out <= 1'b0;
      mem_W_en_out <= 1'b0;
      wb_en_out    <= 1'b0;
      dest_out     <= '0;
      val_rm_out   <= '0;
    end else begin
      stall_out    <= !flush && (mul_start_c || mul_state == MS_MUL);
      out_valid    <= 1'b0;
      status_we    <= 1'b0;
      mem_R_en_out <= 1'b0;
      mem_W_en_out <= 1'b0;
      wb_en_out    <= 1'b0;
      if (alu_fire_c) begin
        out_valid    <= 1'b1;
        alu_result   <= alu_res_c;
        br_addr      <= br_sum_c;
        status       <= s_bit ? alu_nzcv_c : status_reg;
        status_we    <= s_bit;
        mem_R_en_out <= mem_R_en;
        mem_W_en_out <= mem_W_en;
        wb_en_out    <= wb_en;
        dest_out     <= dest;
        val_rm_out   <= val_rm;
      end else if (!flush && mul_state == MS_DONE) begin
        out_valid    <= 1'b1;
        alu_result   <= mul_res_c;
        br_addr      <= mul_br;
        status       <= mul_ctrl.s_bit ? mul_nzcv_c : mul_ctrl.nzcv;
        status_we    <= mul_ctrl.s_bit;
        mem_R_en_out <= mul_ctrl.mem_R_en;
        mem_W_en_out <= mul_ctrl.mem_W_en;
        wb_en_out    <= mul_ctrl.wb_en;
        dest_out     <= mul_ctrl.dest;
        val_rm_out   <= mul_val_rm;
      end
    end
  end

endmodule
